// File: rtl/clk_gen_pkg.sv
// Shared types, constants and helpers for the clock-enable/divider bank.
package clk_gen_pkg;

    localparam int unsigned PKG_CNT_W       = 16;
    localparam int unsigned PKG_DEFAULT_DIV = 2;

    typedef logic [PKG_CNT_W-1:0] cnt_t;

    // Channel-select width, never narrower than one bit.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of high cycles in one period: ceil(div/2).
    function automatic cnt_t hi_len(input cnt_t div);
        logic [PKG_CNT_W:0] sum;
        sum = {1'b0, div} + 1'b1;
        return sum[PKG_CNT_W:1];
    endfunction

    // Counter load value on enable or realign; out-of-range phase falls back to 0.
    function automatic cnt_t phase_eff(input cnt_t div, input cnt_t phase);
        return (phase < div) ? phase : '0;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow/active config, free-running counter, registered outputs.
module clk_div_chan
    import clk_gen_pkg::*;
#(
    parameter int unsigned DEFAULT_DIV = PKG_DEFAULT_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic sync_i,
    input  logic acc_i,
    input  cnt_t div_i,
    input  cnt_t phase_i,
    output logic pending_o,
    output logic clk_o,
    output logic tick_o
);

    cnt_t div_q, div_d, phase_q, phase_d;
    cnt_t sdiv_q, sdiv_d, sphase_q, sphase_d;
    cnt_t cnt_q, cnt_d;
    logic pend_q, pend_d, act_q, act_d;
    logic clk_q, clk_d, tick_q, tick_d;
    logic wrap;

    always_comb begin
        div_d    = div_q;
        phase_d  = phase_q;
        sdiv_d   = sdiv_q;
        sphase_d = sphase_q;
        pend_d   = pend_q;
        act_d    = act_q;
        cnt_d    = cnt_q;
        wrap     = (cnt_q == div_q - 1'b1);

        if (act_q && en_i) begin
            if (sync_i) begin
                // A config arriving with the realign is applied directly, not shadowed.
                if (acc_i) begin
                    div_d   = div_i;
                    phase_d = phase_i;
                end else if (pend_q) begin
                    div_d   = sdiv_q;
                    phase_d = sphase_q;
                    pend_d  = 1'b0;
                end
                act_d = (div_d != '0);
                cnt_d = act_d ? phase_eff(div_d, phase_d) : '0;
            end else begin
                if (wrap) begin
                    if (pend_q) begin
                        div_d   = sdiv_q;
                        phase_d = sphase_q;
                        pend_d  = 1'b0;
                    end
                    cnt_d = '0;
                    act_d = (div_d != '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (acc_i) begin
                    sdiv_d   = div_i;
                    sphase_d = phase_i;
                    pend_d   = 1'b1;
                end
            end
        end else begin
            if (pend_q) begin
                div_d   = sdiv_q;
                phase_d = sphase_q;
                pend_d  = 1'b0;
            end
            if (acc_i) begin
                sdiv_d   = div_i;
                sphase_d = phase_i;
                pend_d   = 1'b1;
            end
            act_d = en_i && (div_d != '0);
            cnt_d = act_d ? phase_eff(div_d, phase_d) : '0;
        end

        tick_d = act_d && (cnt_d == '0);
        clk_d  = act_d && (cnt_d < hi_len(div_d));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q    <= cnt_t'(DEFAULT_DIV);
            phase_q  <= '0;
            sdiv_q   <= '0;
            sphase_q <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            act_q    <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            phase_q  <= phase_d;
            sdiv_q   <= sdiv_d;
            sphase_q <= sphase_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            act_q    <= act_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

    assign pending_o = pend_q;
    assign clk_o     = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel clock-enable/divider bank: config decode plus NUM_CH divider channels.
module clk_div_bank
    import clk_gen_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = PKG_CNT_W,
    parameter int unsigned DEFAULT_DIV = PKG_DEFAULT_DIV,
    localparam int unsigned CH_W       = ch_w(NUM_CH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_req,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] acc;
    logic              sel_pend;

    // Out-of-range channel numbers see no pending flag, so they are always accepted.
    always_comb begin
        sel_pend = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) sel_pend = pending[i];
        end
    end

    assign cfg_ready = ~sys_rst & ~sel_pend;

    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clk_div_chan #(
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_chan (
            .clk_i    (sys_clk),
            .rst_i    (sys_rst),
            .en_i     (ch_en[g]),
            .sync_i   (sync_req),
            .acc_i    (acc[g]),
            .div_i    (cfg_div),
            .phase_i  (cfg_phase),
            .pending_o(pending[g]),
            .clk_o    (clk_out[g]),
            .tick_o   (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomised scoreboard bench for clk_div_bank against a behavioural channel model.
module tb_clk_div_bank;

    localparam int NCH = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [15:0] cfg_phase;
    logic [3:0]  ch_en;
    logic        sync_req;
    logic [3:0]  clk_out;
    logic [3:0]  tick;

    clk_div_bank dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_phase(cfg_phase),
        .ch_en    (ch_en),
        .sync_req (sync_req),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit       rdy;
        bit [3:0] clk;
        bit [3:0] tck;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 0;

    // Model state per channel: running flag, position within period, active/shadow config.
    bit m_run[NCH];
    int m_pos[NCH];
    int m_div[NCH];
    int m_ph[NCH];
    bit m_pend[NCH];
    int m_sdiv[NCH];
    int m_sph[NCH];

    task automatic model_start(input int i);
        m_run[i] = (m_div[i] != 0);
        m_pos[i] = (m_run[i] && m_ph[i] < m_div[i]) ? m_ph[i] : 0;
    endtask

    task automatic model_step(input bit rst, input bit acc, input int ch, input int cd,
                              input int cp, input bit [3:0] en, input bit sync);
        for (int i = 0; i < NCH; i++) begin
            bit a;
            a = acc && (ch == i);
            if (rst) begin
                m_run[i] = 0; m_pos[i] = 0; m_div[i] = 2; m_ph[i] = 0;
                m_pend[i] = 0; m_sdiv[i] = 0; m_sph[i] = 0;
            end else if (m_run[i] && en[i]) begin
                if (sync) begin
                    if (a) begin
                        m_div[i] = cd; m_ph[i] = cp;
                    end else if (m_pend[i]) begin
                        m_div[i] = m_sdiv[i]; m_ph[i] = m_sph[i]; m_pend[i] = 0;
                    end
                    model_start(i);
                end else begin
                    if (m_pos[i] == m_div[i] - 1) begin
                        if (m_pend[i]) begin
                            m_div[i] = m_sdiv[i]; m_ph[i] = m_sph[i]; m_pend[i] = 0;
                        end
                        m_pos[i] = 0;
                        m_run[i] = (m_div[i] != 0);
                    end else begin
                        m_pos[i]++;
                    end
                    if (a) begin
                        m_sdiv[i] = cd; m_sph[i] = cp; m_pend[i] = 1;
                    end
                end
            end else begin
                if (m_pend[i]) begin
                    m_div[i] = m_sdiv[i]; m_ph[i] = m_sph[i]; m_pend[i] = 0;
                end
                if (a) begin
                    m_sdiv[i] = cd; m_sph[i] = cp; m_pend[i] = 1;
                end
                if (en[i]) model_start(i);
                else begin
                    m_run[i] = 0; m_pos[i] = 0;
                end
            end
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show for it.
    task automatic cycle(input bit rst, input bit valid, input int ch, input int cd,
                         input int cp, input bit [3:0] en, input bit sync);
        exp_t e;
        bit   acc;
        @(negedge sys_clk);
        sys_rst   = rst;
        cfg_valid = valid;
        cfg_ch    = 2'(ch);
        cfg_div   = 16'(cd);
        cfg_phase = 16'(cp);
        ch_en     = en;
        sync_req  = sync;
        e.rdy = !rst && !m_pend[ch];
        acc   = valid && e.rdy;
        model_step(rst, acc, ch, cd, cp, en, sync);
        for (int i = 0; i < NCH; i++) begin
            e.tck[i] = m_run[i] && (m_pos[i] == 0);
            e.clk[i] = m_run[i] && (m_pos[i] < (m_div[i] + 1) / 2);
        end
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        bit   r;
        forever begin
            @(negedge sys_clk);
            #2;
            r = cfg_ready;
            @(posedge sys_clk);
            #1;
            if (sb.size() == 0) begin
                if (!done) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard: got empty queue, required an entry");
                end
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (r !== e.rdy) begin
                    n_bad++;
                    $display("FAIL cfg_ready @%0t: got %b required %b", $time, r, e.rdy);
                end
                n_cmp++;
                if (clk_out !== e.clk) begin
                    n_bad++;
                    $display("FAIL clk_out @%0t: got %b required %b", $time, clk_out, e.clk);
                end
                n_cmp++;
                if (tick !== e.tck) begin
                    n_bad++;
                    $display("FAIL tick @%0t: got %b required %b", $time, tick, e.tck);
                end
            end
        end
    end

    initial begin : driver
        bit [3:0] en;
        sys_rst = 1; cfg_valid = 0; cfg_ch = 0; cfg_div = 0; cfg_phase = 0;
        ch_en = 0; sync_req = 0;
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 4'b0000, 0);
        // Default ratio on ch0 only.
        for (int k = 0; k < 12; k++) cycle(0, 0, 0, 0, 0, 4'b0001, 0);
        // ch1 ratio 5, then enable.
        cycle(0, 1, 1, 5, 0, 4'b0001, 0);
        for (int k = 0; k < 15; k++) cycle(0, 0, 0, 0, 0, 4'b0011, 0);
        // ch2 ratio 4 running, retarget to 6 mid-period.
        cycle(0, 1, 2, 4, 0, 4'b0011, 0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 2, 0, 0, 4'b0111, 0);
        for (int k = 0; k < 6; k++) cycle(0, 1, 2, 6, 0, 4'b0111, 0);
        for (int k = 0; k < 14; k++) cycle(0, 0, 2, 0, 0, 4'b0111, 0);
        // ch3 idle ratio, then ratio 1.
        cycle(0, 1, 3, 0, 0, 4'b1111, 0);
        for (int k = 0; k < 6; k++) cycle(0, 0, 3, 0, 0, 4'b1111, 0);
        cycle(0, 1, 3, 1, 0, 4'b1111, 0);
        for (int k = 0; k < 6; k++) cycle(0, 0, 3, 0, 0, 4'b1111, 0);
        // ch0/ch1 ratio 4 with phases 0/2 applied by realign.
        cycle(0, 1, 0, 4, 0, 4'b1111, 0);
        cycle(0, 1, 1, 4, 2, 4'b1111, 0);
        for (int k = 0; k < 8; k++) cycle(0, 0, 0, 0, 0, 4'b1111, 0);
        cycle(0, 0, 0, 0, 0, 4'b1111, 1);
        for (int k = 0; k < 10; k++) cycle(0, 0, 0, 0, 0, 4'b1111, 0);
        // Reset mid-period with a pending config.
        cycle(0, 1, 2, 7, 3, 4'b1111, 0);
        cycle(1, 0, 2, 0, 0, 4'b1111, 0);
        for (int k = 0; k < 6; k++) cycle(0, 0, 2, 0, 0, 4'b0001, 0);

        en = 4'b1111;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NCH; i++) if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
            cycle($urandom_range(0, 399) == 0,
                  $urandom_range(0, 5) == 0,
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 8)),
                  en,
                  $urandom_range(0, 24) == 0);
        end
        done = 1;
        @(posedge sys_clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
